// File: rtl/stack_exec_unit.sv
// Stack-machine execution unit: accepts one instruction per valid/ready handshake,
// executes it against a register-file stack, and reports PC, top-of-stack and depth.
module stack_exec_unit #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] tos,
  output logic [CW-1:0]    count,
  output logic             done,
  output logic             err_ovf,
  output logic             err_unf,
  output logic             err_ill,
  output logic             fault
);

  localparam int            AW    = $clog2(DEPTH);
  localparam int            SLOTS = 1 << AW;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);

  localparam logic [4:0] OP_PUSH = 5'd0;
  localparam logic [4:0] OP_POP  = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_NEG  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_NOT  = 5'd5;
  localparam logic [4:0] OP_CALL = 5'd6;
  localparam logic [4:0] OP_RET  = 5'd7;
  localparam logic [4:0] OP_DUP  = 5'd8;
  localparam logic [4:0] OP_SWAP = 5'd9;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t state, state_next;

  logic        [WIDTH-1:0] stack_mem [SLOTS];
  logic        [WIDTH-1:0] instr_p0;

  logic        [4:0]       opcode;
  logic signed [WIDTH-1:0] imm;
  logic        [AW-1:0]    top_idx, sec_idx, push_idx;
  logic        [WIDTH-1:0] top_val, sec_val;
  logic                    has1, has2, full;

  logic                    wr0_en, wr1_en;
  logic        [AW-1:0]    wr0_idx, wr1_idx;
  logic        [WIDTH-1:0] wr0_data, wr1_data;
  logic        [CW-1:0]    count_next;
  logic        [WIDTH-1:0] pc_next;
  logic                    ovf, unf, ill;
  logic                    exec_now;

  function automatic logic signed [WIDTH-1:0] sext_imm(input logic [WIDTH-1:0] word);
    return {{5{word[WIDTH-6]}}, word[WIDTH-6:0]};
  endfunction

  // Control state
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = EXEC;
      end
      EXEC: state_next = IDLE;
    endcase
  end

  assign exec_now = (state == EXEC);

  // Stage p0: decode the latched instruction against the current stack
  assign opcode   = instr_p0[WIDTH-1:WIDTH-5];
  assign imm      = sext_imm(instr_p0);
  assign top_idx  = AW'(count - CW'(1));
  assign sec_idx  = AW'(count - CW'(2));
  assign push_idx = AW'(count);
  assign top_val  = stack_mem[top_idx];
  assign sec_val  = stack_mem[sec_idx];
  assign has1     = (count != '0);
  assign has2     = (count > CW'(1));
  assign full     = (count == FULL);

  always_comb begin
    wr0_en     = 1'b0;
    wr0_idx    = push_idx;
    wr0_data   = $unsigned(imm);
    wr1_en     = 1'b0;
    wr1_idx    = sec_idx;
    wr1_data   = top_val;
    count_next = count;
    pc_next    = pc + WIDTH'(1);
    ovf        = 1'b0;
    unf        = 1'b0;
    ill        = 1'b0;
    case (opcode)
      OP_PUSH: begin
        if (full) ovf = 1'b1;
        else begin
          wr0_en     = 1'b1;
          count_next = count + CW'(1);
        end
      end
      OP_POP: begin
        if (!has1) unf = 1'b1;
        else count_next = count - CW'(1);
      end
      OP_ADD, OP_OR: begin
        // Two pops and one push: net -1, so only underflow can occur
        if (!has2) unf = 1'b1;
        else begin
          wr0_en     = 1'b1;
          wr0_idx    = sec_idx;
          wr0_data   = (opcode == OP_ADD) ? (top_val + sec_val) : (top_val | sec_val);
          count_next = count - CW'(1);
        end
      end
      OP_NEG, OP_NOT: begin
        if (!has1) unf = 1'b1;
        else begin
          wr0_en   = 1'b1;
          wr0_idx  = top_idx;
          wr0_data = (opcode == OP_NEG) ? (~top_val + WIDTH'(1)) : ~top_val;
        end
      end
      OP_CALL: begin
        if (full) ovf = 1'b1;
        else begin
          wr0_en     = 1'b1;
          wr0_data   = pc + WIDTH'(1);
          count_next = count + CW'(1);
          pc_next    = pc + WIDTH'(1) + $unsigned(imm);
        end
      end
      OP_RET: begin
        if (!has1) unf = 1'b1;
        else begin
          count_next = count - CW'(1);
          pc_next    = top_val;
        end
      end
      OP_DUP: begin
        if (!has1) unf = 1'b1;
        else if (full) ovf = 1'b1;
        else begin
          wr0_en     = 1'b1;
          wr0_data   = top_val;
          count_next = count + CW'(1);
        end
      end
      OP_SWAP: begin
        if (!has2) unf = 1'b1;
        else begin
          wr0_en   = 1'b1;
          wr0_idx  = top_idx;
          wr0_data = sec_val;
          wr1_en   = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
  end

  // Stage p1: commit architectural state and status pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      pc      <= '0;
      count   <= '0;
      done    <= 1'b0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      err_ill <= 1'b0;
      fault   <= 1'b0;
    end else begin
      done    <= exec_now;
      err_ovf <= exec_now & ovf;
      err_unf <= exec_now & unf;
      err_ill <= exec_now & ill;
      fault   <= fault | (exec_now & (ovf | unf | ill));
      if (exec_now) begin
        pc    <= pc_next;
        count <= count_next;
      end
    end
  end

  // Data storage is not reset; an aborted instruction must still not write
  always_ff @(posedge clock) begin
    if (state == IDLE && instr_valid) instr_p0 <= instr;
    if (exec_now && !reset) begin
      if (wr0_en) stack_mem[wr0_idx] <= wr0_data;
      if (wr1_en) stack_mem[wr1_idx] <= wr1_data;
    end
  end

  assign tos = has1 ? top_val : '0;

endmodule

// File: tb/tb_stack_exec_unit.sv
// Bench for stack_exec_unit: queue-based reference model checked every cycle,
// plus directed instruction sequences with hand-computed expectations.
`timescale 1ns/1ps
module tb_stack_exec_unit;

  localparam int W = 16;
  localparam int D = 4;
  localparam int CW = $clog2(D + 1);

  logic          clock;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [W-1:0]  instr;
  logic [W-1:0]  pc;
  logic [W-1:0]  tos;
  logic [CW-1:0] count;
  logic          done, err_ovf, err_unf, err_ill, fault;

  stack_exec_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .tos(tos), .count(count), .done(done),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_ill(err_ill), .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stack as a queue, one pending instruction between handshake and commit
  logic [W-1:0] m_stk[$];
  logic [W-1:0] m_pc = '0;
  logic [W-1:0] m_instr = '0;
  bit m_busy = 0, m_done = 0, m_ovf = 0, m_unf = 0, m_ill = 0, m_fault = 0, m_started = 0;

  task automatic model_exec(input logic [W-1:0] i);
    logic [4:0]   op;
    logic [W-1:0] sx, a, b;
    bit           jumped;
    op = i[W-1:W-5];
    sx = {{5{i[W-6]}}, i[W-6:0]};
    jumped = 0;
    case (op)
      5'd0: if (m_stk.size() >= D) m_ovf = 1; else m_stk.push_back(sx);
      5'd1: if (m_stk.size() < 1) m_unf = 1; else a = m_stk.pop_back();
      5'd2: if (m_stk.size() < 2) m_unf = 1;
            else begin a = m_stk.pop_back(); b = m_stk.pop_back(); m_stk.push_back(a + b); end
      5'd3: if (m_stk.size() < 1) m_unf = 1; else m_stk[$] = -m_stk[$];
      5'd4: if (m_stk.size() < 2) m_unf = 1;
            else begin a = m_stk.pop_back(); b = m_stk.pop_back(); m_stk.push_back(a | b); end
      5'd5: if (m_stk.size() < 1) m_unf = 1; else m_stk[$] = ~m_stk[$];
      5'd6: if (m_stk.size() >= D) m_ovf = 1;
            else begin m_stk.push_back(m_pc + 16'd1); m_pc = m_pc + 16'd1 + sx; jumped = 1; end
      5'd7: if (m_stk.size() < 1) m_unf = 1;
            else begin m_pc = m_stk.pop_back(); jumped = 1; end
      5'd8: if (m_stk.size() < 1) m_unf = 1;
            else if (m_stk.size() >= D) m_ovf = 1;
            else m_stk.push_back(m_stk[$]);
      5'd9: if (m_stk.size() < 2) m_unf = 1;
            else begin a = m_stk.pop_back(); b = m_stk.pop_back(); m_stk.push_back(a); m_stk.push_back(b); end
      default: m_ill = 1;
    endcase
    if (!jumped) m_pc = m_pc + 16'd1;
    if (m_ovf || m_unf || m_ill) m_fault = 1;
  endtask

  always @(posedge clock) begin
    m_started = 1;
    if (reset) begin
      m_stk.delete();
      m_pc = '0; m_busy = 0; m_done = 0; m_ovf = 0; m_unf = 0; m_ill = 0; m_fault = 0;
    end else begin
      m_done = 0; m_ovf = 0; m_unf = 0; m_ill = 0;
      if (m_busy) begin
        model_exec(m_instr);
        m_done = 1;
        m_busy = 0;
      end else if (instr_valid) begin
        m_instr = instr;
        m_busy = 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    if (m_started) begin
      check("ready", instr_ready, !m_busy);
      check("pc", pc, m_pc);
      check("count", count, m_stk.size());
      check("tos", tos, (m_stk.size() == 0) ? 16'h0 : m_stk[$]);
      check("done", done, m_done);
      check("err_ovf", err_ovf, m_ovf);
      check("err_unf", err_unf, m_unf);
      check("err_ill", err_ill, m_ill);
      check("fault", fault, m_fault);
    end
  end

  // Called #1 after a rising edge; returns #1 after the commit edge (done cycle)
  task automatic issue(input logic [W-1:0] i);
    int k;
    k = 0;
    while (instr_ready !== 1'b1 && k < 10) begin
      @(posedge clock); #1; k++;
    end
    check("ready_wait", instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr = i;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    instr = ~i;
    @(posedge clock); #1;
    if (done === 1'b1) n_done++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_pc", pc, 0);
    check("rst_count", count, 0);
    check("rst_tos", tos, 0);
    check("rst_ready", instr_ready, 1);
    check("rst_fault", fault, 0);

    // Arithmetic
    issue(16'h0002); issue(16'h0004); issue(16'h1000);
    check("add_tos", tos, 16'h0006);
    check("add_count", count, 1);
    check("add_pc", pc, 3);
    check("add_dones", n_done, 3);

    // Unary and stack ops
    issue(16'h1800); check("neg_tos", tos, 16'hFFFA);
    issue(16'h2800); check("not_tos", tos, 16'h0005);
    issue(16'h4000); check("dup_count", count, 2);
    issue(16'h0007); issue(16'h4800);
    check("swap_tos", tos, 16'h0005);
    check("swap_count", count, 3);

    // Overflow
    do_reset();
    issue(16'h0001); issue(16'h0002); issue(16'h0003); issue(16'h0004);
    check("full_count", count, 4);
    issue(16'h0005);
    check("ovf_pulse", err_ovf, 1);
    check("ovf_count", count, 4);
    check("ovf_tos", tos, 16'h0004);
    check("ovf_pc", pc, 5);
    check("ovf_fault", fault, 1);

    // Underflow
    do_reset();
    issue(16'h0800);
    check("pop_unf", err_unf, 1);
    check("pop_count", count, 0);
    issue(16'h0001); issue(16'h1000);
    check("add_unf", err_unf, 1);
    check("add_unf_count", count, 1);
    check("add_unf_tos", tos, 16'h0001);
    check("add_unf_pc", pc, 3);

    // CALL / RET
    do_reset();
    issue(16'h0001); issue(16'h0002); issue(16'h0800);
    check("pre_call_pc", pc, 3);
    issue(16'h3005);
    check("call_pc", pc, 9);
    check("call_tos", tos, 16'h0004);
    check("call_count", count, 2);
    issue(16'h3800);
    check("ret_pc", pc, 4);
    check("ret_count", count, 1);
    issue(16'h37FE);
    check("callneg_pc", pc, 3);
    check("callneg_tos", tos, 16'h0005);
    issue(16'h07FF);
    check("push_m1", tos, 16'hFFFF);
    issue(16'h3800);
    check("ret_ffff", pc, 16'hFFFF);
    issue(16'h3000);
    check("call_wrap_pc", pc, 16'h0000);
    check("call_wrap_tos", tos, 16'h0000);
    check("call_wrap_count", count, 3);

    // Illegal opcodes
    issue(16'h5000);
    check("ill_pulse", err_ill, 1);
    check("ill_pc", pc, 1);
    check("ill_count", count, 3);
    check("ill_fault", fault, 1);
    issue(16'hF800);
    check("ill2_pulse", err_ill, 1);
    check("ill2_pc", pc, 2);

    // Back-to-back handshake with instr_valid held high
    do_reset();
    instr_valid = 1'b1;
    instr = 16'h0001;
    check("hs_ready0", instr_ready, 1);
    @(posedge clock); #1 check("hs_ready1", instr_ready, 0);
    @(posedge clock); #1 check("hs_ready2", instr_ready, 1);
    check("hs_done2", done, 1);
    @(posedge clock); #1 check("hs_ready3", instr_ready, 0);
    @(posedge clock); #1 check("hs_count", count, 2);
    instr_valid = 1'b0;

    // Reset during EXEC
    @(posedge clock); #1;
    issue(16'h5000);
    check("pre_abort_fault", fault, 1);
    instr_valid = 1'b1;
    instr = 16'h0009;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_done", done, 0);
    check("abort_pc", pc, 0);
    check("abort_count", count, 0);
    check("abort_tos", tos, 0);
    check("abort_fault", fault, 0);
    check("abort_ready", instr_ready, 1);

    repeat (3) @(posedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
